adc_sample_fifo_mc: RTL and testbench

//  Multi-channel, channel-tagged sample FIFO between the ADC capture front end and the

---
 rtl/adc_sample_fifo_mc.sv | 150 +++++++++++++++
 tb/tb_adc_sample_fifo_mc.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_fifo_mc.sv
// Channel-tagged ADC sample FIFO: NCH interleaved channels share one dual-port RAM.
// First-word-fall-through output register, almost flags, drop-newest/overwrite-oldest overflow.
module adc_sample_fifo_mc #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned NCH        = 4,
    parameter int unsigned AE_THRESH  = 8,
    parameter int unsigned AF_THRESH  = (2 ** ADDR_WIDTH) - 3,
    parameter int unsigned CNT_WIDTH  = 16,
    localparam int unsigned CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [CH_W-1:0]       in_ch,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CH_W-1:0]       out_ch,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    input  logic                  ovf_mode,
    output logic                  ovf_sticky,
    output logic [CNT_WIDTH-1:0]  ovf_count,
    input  logic                  clr_ovf
);
    localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
    localparam int unsigned WORD_W = CH_W + DATA_WIDTH;
    localparam int unsigned LVL_W  = ADDR_WIDTH + 1;

    // Every stored word, including the presented one, lives in RAM at r_rd_ptr;
    // the output register is a prefetched copy of that head slot.
    logic [WORD_W-1:0]     r_mem [DEPTH];
    logic [WORD_W-1:0]     r_ram_q;
    logic [WORD_W-1:0]     r_fwd_word;
    logic                  r_fwd_sel;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic                  r_out_valid;
    logic                  r_ovf_sticky;
    logic [CNT_WIDTH-1:0]  r_ovf_count;

    logic                  w_full;
    logic                  w_pop;
    logic                  w_ovf;
    logic                  w_overwrite;
    logic                  w_push;
    logic                  w_wr;
    logic                  w_adv;
    logic                  w_load;
    logic                  w_collide;
    logic                  w_out_valid_next;
    logic [ADDR_WIDTH-1:0] w_wr_ptr_next;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_next;
    logic [LVL_W-1:0]      w_level_next;
    logic [WORD_W-1:0]     w_in_word;
    logic [WORD_W-1:0]     w_out_word;

    assign w_full        = (r_level == LVL_W'(DEPTH));
    assign w_pop         = r_out_valid & out_ready;
    assign w_ovf         = in_valid & w_full & ~w_pop;
    assign w_overwrite   = w_ovf & ovf_mode;
    assign w_push        = in_valid & ~w_ovf;
    assign w_wr          = w_push | w_overwrite;
    assign w_adv         = w_pop | w_overwrite;
    assign w_wr_ptr_next = w_wr  ? r_wr_ptr + ADDR_WIDTH'(1) : r_wr_ptr;
    assign w_rd_ptr_next = w_adv ? r_rd_ptr + ADDR_WIDTH'(1) : r_rd_ptr;
    assign w_in_word     = {in_ch, in_data};

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + LVL_W'(1);
        end else if (w_pop && !w_push) begin
            w_level_next = r_level - LVL_W'(1);
        end
    end

    // A word pushed into an empty FIFO is only fetched on the following edge.
    always_comb begin
        w_out_valid_next = 1'b0;
        if (w_level_next != '0) begin
            if (r_out_valid) begin
                w_out_valid_next = 1'b1;
            end else begin
                w_out_valid_next = (r_level != '0);
            end
        end
    end

    assign w_load    = w_out_valid_next & (~r_out_valid | w_adv);
    assign w_collide = w_wr & (r_wr_ptr == w_rd_ptr_next);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_in_word;
        end
        if (w_load) begin
            r_ram_q <= r_mem[w_rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_out_valid  <= 1'b0;
            r_fwd_sel    <= 1'b1;
            r_fwd_word   <= '0;
            r_ovf_sticky <= 1'b0;
            r_ovf_count  <= '0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_next;
            r_rd_ptr    <= w_rd_ptr_next;
            r_level     <= w_level_next;
            r_out_valid <= w_out_valid_next;
            // The RAM read returns the old contents on a same-address write, so take in_data.
            if (w_load) begin
                r_fwd_sel  <= w_collide;
                r_fwd_word <= w_in_word;
            end
            if (clr_ovf) begin
                r_ovf_sticky <= w_ovf;
                r_ovf_count  <= w_ovf ? CNT_WIDTH'(1) : '0;
            end else if (w_ovf) begin
                r_ovf_sticky <= 1'b1;
                if (r_ovf_count != '1) begin
                    r_ovf_count <= r_ovf_count + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign w_out_word   = r_fwd_sel ? r_fwd_word : r_ram_q;
    assign out_valid    = r_out_valid;
    assign out_data     = w_out_word[DATA_WIDTH-1:0];
    assign out_ch       = w_out_word[WORD_W-1 -: CH_W];
    assign level        = r_level;
    assign full         = w_full;
    assign almost_full  = (32'(r_level) >= AF_THRESH);
    assign almost_empty = (32'(r_level) < AE_THRESH);
    assign ovf_sticky   = r_ovf_sticky;
    assign ovf_count    = r_ovf_count;

endmodule

// File: tb/tb_adc_sample_fifo_mc.sv
// Bench for adc_sample_fifo_mc: directed vector table, scenario sequences and a
// randomized run checked every cycle against a queue-based reference model.
module tb_adc_sample_fifo_mc;
    localparam int DW    = 16;
    localparam int AW    = 9;
    localparam int NCH   = 4;
    localparam int CW    = 2;
    localparam int CNTW  = 16;
    localparam int DEPTH = 512;
    localparam int AE    = 8;
    localparam int AF    = 509;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [CW-1:0]   in_ch;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [CW-1:0]   out_ch;
    logic [AW:0]     level;
    logic            full;
    logic            almost_full;
    logic            almost_empty;
    logic            ovf_mode;
    logic            ovf_sticky;
    logic [CNTW-1:0] ovf_count;
    logic            clr_ovf;

    always #5 clk = ~clk;

    adc_sample_fifo_mc #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NCH(NCH),
        .AE_THRESH(AE), .AF_THRESH(AF), .CNT_WIDTH(CNTW)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
        .level(level), .full(full), .almost_full(almost_full), .almost_empty(almost_empty),
        .ovf_mode(ovf_mode), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count), .clr_ovf(clr_ovf)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of {ch,data} words plus overflow accounting.
    logic [17:0] m_q[$];
    bit          m_valid;
    bit          m_sticky;
    int          m_count;

    logic [17:0] got[$];
    logic [17:0] exp_q[$];

    typedef struct {
        logic        iv;
        logic [1:0]  ch;
        logic [15:0] d;
        logic        rdy;
        logic        clr;
        logic        ev;
        int          elvl;
        logic        chkw;
        logic [17:0] ew;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 100)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int sz;
        bit pop;
        bit ovf;
        if (reset) begin
            m_q.delete();
            m_valid  = 0;
            m_sticky = 0;
            m_count  = 0;
            return;
        end
        sz  = m_q.size();
        pop = m_valid && out_ready;
        ovf = in_valid && (sz == DEPTH) && !pop;
        if (pop) void'(m_q.pop_front());
        if (in_valid && !ovf) begin
            m_q.push_back({in_ch, in_data});
        end else if (ovf && ovf_mode) begin
            void'(m_q.pop_front());
            m_q.push_back({in_ch, in_data});
        end
        if (clr_ovf) begin
            m_sticky = ovf;
            m_count  = ovf ? 1 : 0;
        end else if (ovf) begin
            m_sticky = 1;
            if (m_count < 65535) m_count++;
        end
        m_valid = (m_q.size() > 0) && (sz > 0);
    endtask

    task automatic compare_model();
        int n;
        n = m_q.size();
        chk("m_valid",  32'(out_valid), 32'(m_valid));
        chk("m_level",  32'(level), 32'(n));
        chk("m_full",   32'(full), 32'(n == DEPTH));
        chk("m_afull",  32'(almost_full), 32'(n >= AF));
        chk("m_aempty", 32'(almost_empty), 32'(n < AE));
        chk("m_sticky", 32'(ovf_sticky), 32'(m_sticky));
        chk("m_count",  32'(ovf_count), 32'(m_count));
        if (m_valid) chk("m_word", 32'({out_ch, out_data}), 32'(m_q[0]));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        reset = 1; in_valid = 0; out_ready = 0; clr_ovf = 0; ovf_mode = 0;
        step();
        reset = 0;
    endtask

    task automatic fill(input int n, input int base);
        out_ready = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1; in_ch = 2'(i % 4); in_data = 16'(base + i);
            step();
        end
        in_valid = 0;
    endtask

    task automatic drain(input int maxc);
        got.delete();
        out_ready = 1;
        for (int c = 0; c < maxc; c++) begin
            if (out_valid) got.push_back({out_ch, out_data});
            else if (level == 0) break;
            step();
        end
        out_ready = 0;
    endtask

    task automatic cmp_seq(input string name);
        int nbad;
        nbad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= got.size() || got[i] !== exp_q[i]) nbad++;
        chk({name, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        chk({name, "_order"}, 32'(nbad), 0);
    endtask

    initial begin
        int  bubbles;
        int  nbeef;
        bit  started;
        int  pin;
        int  prd;

        reset = 1; in_valid = 0; in_ch = 0; in_data = 0;
        out_ready = 0; ovf_mode = 0; clr_ovf = 0;

        //               iv   ch    data      rdy  clr  ev  lvl chkw  word
        vecs[0]  = '{1'b1, 2'd1, 16'h0123, 1'b0, 1'b0, 1'b0, 1, 1'b0, 18'h00000};
        vecs[1]  = '{1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 1'b1, 18'h10123};
        vecs[2]  = '{1'b1, 2'd2, 16'h0456, 1'b0, 1'b0, 1'b1, 2, 1'b1, 18'h10123};
        vecs[3]  = '{1'b1, 2'd3, 16'h0789, 1'b1, 1'b0, 1'b1, 2, 1'b1, 18'h20456};
        vecs[4]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1, 1'b1, 18'h30789};
        vecs[5]  = '{1'b1, 2'd0, 16'h0AAA, 1'b1, 1'b0, 1'b1, 1, 1'b1, 18'h00AAA};
        vecs[6]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 18'h00000};
        vecs[7]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 18'h00000};
        vecs[8]  = '{1'b1, 2'd3, 16'h0FFF, 1'b1, 1'b0, 1'b0, 1, 1'b0, 18'h00000};
        vecs[9]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1, 1'b1, 18'h30FFF};
        vecs[10] = '{1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 18'h00000};
        vecs[11] = '{1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 0, 1'b0, 18'h00000};

        step(); step();
        reset = 0;
        chk("rst_valid",  32'(out_valid), 0);
        chk("rst_level",  32'(level), 0);
        chk("rst_full",   32'(full), 0);
        chk("rst_afull",  32'(almost_full), 0);
        chk("rst_aempty", 32'(almost_empty), 1);
        chk("rst_sticky", 32'(ovf_sticky), 0);
        chk("rst_count",  32'(ovf_count), 0);
        chk("rst_word",   32'({out_ch, out_data}), 0);
        $display("reset: valid=%0d level=%0d aempty=%0d", out_valid, level, almost_empty);

        for (int i = 0; i < 12; i++) begin
            in_valid = vecs[i].iv; in_ch = vecs[i].ch; in_data = vecs[i].d;
            out_ready = vecs[i].rdy; clr_ovf = vecs[i].clr;
            step();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].elvl));
            if (vecs[i].chkw)
                chk($sformatf("vec%0d_word", i), 32'({out_ch, out_data}), 32'(vecs[i].ew));
            $display("vec %0d: valid=%0d level=%0d ch=%0d data=%h", i, out_valid, level, out_ch, out_data);
        end
        in_valid = 0; out_ready = 0; clr_ovf = 0;

        // Streaming 512 words with the consumer always ready
        do_reset();
        got.delete(); bubbles = 0; started = 0;
        for (int c = 0; c < 600; c++) begin
            if (c < 512) begin
                in_valid = 1; in_ch = 2'(c % 4); in_data = 16'(c);
            end else begin
                in_valid = 0;
            end
            if (out_valid) begin
                started = 1; out_ready = 1;
                got.push_back({out_ch, out_data});
            end else if (started && got.size() < 512) begin
                bubbles++;
            end
            step();
        end
        in_valid = 0; out_ready = 0;
        exp_q.delete();
        for (int i = 0; i < 512; i++) exp_q.push_back({2'(i % 4), 16'(i)});
        cmp_seq("t2");
        chk("t2_bubbles", 32'(bubbles), 0);
        chk("t2_level", 32'(level), 0);
        chk("t2_count", 32'(ovf_count), 0);
        $display("stream: words=%0d bubbles=%0d", got.size(), bubbles);

        // Drop-newest overflow
        do_reset();
        fill(512, 0);
        ovf_mode = 0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1; in_ch = 0; in_data = 16'hBEEF;
            step();
        end
        in_valid = 0;
        chk("t3_full", 32'(full), 1);
        chk("t3_count", 32'(ovf_count), 3);
        chk("t3_sticky", 32'(ovf_sticky), 1);
        drain(600);
        nbeef = 0;
        foreach (got[i]) if (got[i][15:0] == 16'hBEEF) nbeef++;
        cmp_seq("t3");
        chk("t3_beef", 32'(nbeef), 0);
        $display("drop-newest: words=%0d ovf_count=%0d", got.size(), ovf_count);

        // Overwrite-oldest overflow
        do_reset();
        fill(512, 0);
        ovf_mode = 1;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1; in_ch = 2'(k); in_data = 16'(16'hA000 + k);
            step();
        end
        in_valid = 0; ovf_mode = 0;
        chk("t4_count", 32'(ovf_count), 2);
        chk("t4_level", 32'(level), 512);
        chk("t4_head", 32'(out_data), 2);
        chk("t4_hvalid", 32'(out_valid), 1);
        drain(600);
        exp_q.delete();
        for (int i = 2; i < 512; i++) exp_q.push_back({2'(i % 4), 16'(i)});
        exp_q.push_back({2'd0, 16'hA000});
        exp_q.push_back({2'd1, 16'hA001});
        cmp_seq("t4");
        $display("overwrite-oldest: words=%0d first=%h", got.size(), got.size() > 0 ? got[0] : 18'h0);

        // Push+pop while full, then counter clear cases
        do_reset();
        fill(512, 0);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1; out_ready = 1; in_ch = 2'(k % 4); in_data = 16'(16'h5000 + k);
            step();
        end
        in_valid = 0; out_ready = 0;
        chk("t5_level", 32'(level), 512);
        chk("t5_count", 32'(ovf_count), 0);
        chk("t5_sticky", 32'(ovf_sticky), 0);
        in_valid = 1; in_ch = 0; in_data = 16'hDEAD;
        step();
        in_valid = 0;
        chk("t5_ovf_count", 32'(ovf_count), 1);
        chk("t5_ovf_sticky", 32'(ovf_sticky), 1);
        clr_ovf = 1;
        step();
        chk("t5_clr_count", 32'(ovf_count), 0);
        chk("t5_clr_sticky", 32'(ovf_sticky), 0);
        in_valid = 1; in_data = 16'hDEAD;
        step();
        in_valid = 0; clr_ovf = 0;
        chk("t5_both_count", 32'(ovf_count), 1);
        chk("t5_both_sticky", 32'(ovf_sticky), 1);
        drain(600);
        exp_q.delete();
        for (int i = 10; i < 512; i++) exp_q.push_back({2'(i % 4), 16'(i)});
        for (int k = 0; k < 10; k++) exp_q.push_back({2'(k % 4), 16'(16'h5000 + k)});
        cmp_seq("t5");
        $display("full push+pop: words=%0d", got.size());

        // Reset in the middle of operation
        do_reset();
        fill(300, 0);
        step();
        chk("t6_pre_level", 32'(level), 300);
        chk("t6_pre_valid", 32'(out_valid), 1);
        reset = 1; in_valid = 1; in_ch = 1; in_data = 16'h7777;
        step();
        reset = 0; in_valid = 0;
        chk("t6_level", 32'(level), 0);
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_aempty", 32'(almost_empty), 1);
        in_valid = 1; in_ch = 2; in_data = 16'h1234;
        step();
        in_valid = 0;
        chk("t6_push_valid1", 32'(out_valid), 0);
        step();
        chk("t6_push_valid2", 32'(out_valid), 1);
        chk("t6_push_word", 32'({out_ch, out_data}), 32'(18'h21234));
        $display("mid-op reset: level=%0d valid=%0d", level, out_valid);

        // Randomized traffic, alternating fill-heavy and drain-heavy phases
        do_reset();
        for (int ph = 0; ph < 8; ph++) begin
            pin = (ph % 2 == 0) ? 90 : 30;
            prd = (ph % 2 == 0) ? 15 : 80;
            for (int c = 0; c < 800; c++) begin
                in_valid  = ($urandom_range(99) < pin);
                in_ch     = 2'($urandom_range(3));
                in_data   = 16'($urandom);
                out_ready = ($urandom_range(99) < prd);
                clr_ovf   = ($urandom_range(99) < 2);
                reset     = ($urandom_range(1999) == 0);
                if (c % 50 == 0) ovf_mode = 1'($urandom_range(1));
                step();
            end
            $display("random phase %0d: level=%0d ovf_count=%0d", ph, level, ovf_count);
        end
        reset = 0; in_valid = 0; out_ready = 0; clr_ovf = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
